alu_sweep_checker: RTL
======================

Name: alu_sweep_checker

Overview:
- Self-checking stimulus engine for SM83-style ALU cores; generalised successor of the cyclic a+b operand sweep.
- Walks every operand pair (a,b) over 0..2^WIDTH-1 for each operation enabled in MODE_MASK.
- Drives the ALU under test and samples its result and flags LAT cycles later.
- Compares against a built-in golden model; accumulates mismatch statistics.

Parameters:
WIDTH, 8, operand/result width in bits; even, 4..16
LAT, 1, cycles from operand apply edge to DUT sample edge; >=1
MODE_MASK, 8'hFF, bit k enables op k (0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP)
ERRW, 16, width of err_count

Ports:
CLK  in  1  system clock, all state on rising edge
RESET  in  1  synchronous, active-high
start  in  1  begin sweep; sampled in IDLE or DONE only
abort  in  1  stop sweep; return to IDLE next edge
cin  in  1  carry-in used for ADC/SBC on every vector
op_a  out  WIDTH  operand A to DUT
op_b  out  WIDTH  operand B to DUT
op_sel  out  3  current op code to DUT
op_cin  out  1  carry-in to DUT (cin for ADC/SBC, 0 otherwise)
dut_res  in  WIDTH  DUT result
dut_flags  in  4  DUT {Z,N,H,C}
busy  out  1  sweep in progress
done  out  1  level; sweep completed, held until next start/RESET
err_count  out  ERRW  mismatches, saturating at all-ones
first_err_valid  out  1  first mismatch captured
first_err  out  2*WIDTH+3  {op, a, b} of first mismatch

Behaviour:
- Reset values: all outputs 0; state IDLE; a=b=op=0.
- States: IDLE, APPLY, WAIT, CHECK, NEXT, DONE.
- IDLE/DONE + start: clear err_count, first_err*, done. Load op = lowest enabled bit of MODE_MASK, a=b=0. Go APPLY. busy=1 from this edge.
- MODE_MASK==0: start goes straight to DONE with err_count=0.
- APPLY: op_a/op_b/op_sel/op_cin update at this edge (E0).
- WAIT: idle LAT-1 cycles; skipped when LAT=1.
- CHECK: dut_res/dut_flags sampled at edge E0+LAT; compared with golden for the registered operands.
- Mismatch: err_count+1 (saturate, no wrap). The first mismatch also sets first_err_valid and first_err.
- NEXT: b increments. On b wrap, a increments. On a wrap, advance to the next enabled op. After the last op, go DONE.
- Vector period = LAT+1 cycles. Sweep length = nops * 2^(2*WIDTH) * (LAT+1) cycles, plus 1 start cycle.
- DONE: busy=0, done=1; op_* hold last vector.
- abort (any state except IDLE): IDLE next edge. busy=0, done=0; counters retained for inspection.
- abort and start in the same cycle: abort wins.
- start while busy: ignored.
- RESET mid-sweep: everything returns to reset values at that edge; no partial done.
- Golden model (mod 2^WIDTH), H = carry/borrow out of bit WIDTH/2-1:
  - ADD/ADC: r=a+b(+cin). N=0. C=carry out of MSB.
  - SUB/SBC: r=a-b(-cin). N=1. C=borrow.
  - AND: N=0, H=1, C=0.
  - XOR/OR: N=0, H=0, C=0.
  - CP: flags as SUB. dut_res not compared.
  - All ops: Z=(r==0).
- Comparison covers full WIDTH result plus all four flags. Any X/Z on DUT inputs counts as a mismatch.

Decomposition:
- Shared include alu_sweep_defs.vh: op code constants (ADD..CP), state encodings, flag bit positions {Z=3,N=2,H=1,C=0}.
- Sub-module alu_golden: purely combinational, parameter WIDTH, inputs op/a/b/cin, outputs res/flags. Reusable by other ALU benches.
- FSM, counters and statistics stay in alu_sweep_checker.

Test Plan:
- WIDTH=4, LAT=1, MODE_MASK=8'h01, DUT = alu_golden instance -> done after 1+256*2=513 cycles, err_count=0, first_err_valid=0.
- WIDTH=4, MODE_MASK=8'h01, DUT result bit0 stuck-at-0 -> err_count=128; first_err={ADD,a=0,b=1}.
- WIDTH=4, LAT=3, MODE_MASK=8'h84 (SUB,CP), correct DUT, cin=1 -> 2*256*4+1=2049 cycles to done. err_count=0. op_sel order SUB then CP.
- WIDTH=4, DUT H flag forced 0, MODE_MASK=8'h10 (AND) -> err_count=256. ERRW=4 variant saturates at 15.
- Issue abort at cycle 100 -> busy=0 and done=0 next edge; counters retained. New start clears them and restarts at a=b=0.
- Assert RESET mid-sweep, with start held high during the same cycle -> all outputs 0 after the edge, state IDLE. MODE_MASK=0 start -> done=1 one edge later.

Source files
------------

// File: rtl/alu_sweep_checker_pkg.sv
// Shared constants for the ALU sweep checker.
// Op codes, FSM encodings, flag positions, op-walk helper.
package alu_sweep_checker_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_CP  = 3'd7;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_APPLY = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int F_Z = 3;
    localparam int F_N = 2;
    localparam int F_H = 1;
    localparam int F_C = 0;

    // Lowest enabled op code >= from; bit 3 flags "found".
    function automatic logic [3:0] op_after(
        input logic [7:0] m,
        input logic [3:0] from
    );
        op_after = 4'b0;
        for (int k = 7; k >= 0; k--) begin
            if (m[k] && k >= int'(from)) begin
                op_after = {1'b1, 3'(k)};
            end
        end
    endfunction

endpackage

// File: rtl/alu_sweep_checker_if.sv
// Operand/result bus between sweep checker and ALU under test.
// Checker is master (drives operands), ALU is slave.
interface alu_sweep_checker_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [2:0]       op_sel;
    logic             op_cin;
    logic [WIDTH-1:0] dut_res;
    logic [3:0]       dut_flags;

    modport master (
        output op_a, op_b, op_sel, op_cin,
        input  dut_res, dut_flags
    );
    modport slave (
        input  op_a, op_b, op_sel, op_cin,
        output dut_res, dut_flags
    );
endinterface

// File: rtl/alu_sweep_checker_golden.sv
// Combinational SM83-style ALU reference model.
// H is the carry/borrow out of the low half of the operands.
module alu_golden
    import alu_sweep_checker_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       flags
);
    localparam int HW = WIDTH / 2;

    logic           c;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] dif;
    logic [HW:0]    hsum;
    logic [HW:0]    hdif;

    // Arithmetic on widened operands so carries/borrows land in the top bit.
    always_comb begin
        c     = cin & ((op == OP_ADC) | (op == OP_SBC));
        sum   = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(c);
        dif   = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(c);
        hsum  = {1'b0, a[HW-1:0]} + {1'b0, b[HW-1:0]} + (HW+1)'(c);
        hdif  = {1'b0, a[HW-1:0]} - {1'b0, b[HW-1:0]} - (HW+1)'(c);
        res   = '0;
        flags = '0;
        unique case (op)
            OP_ADD, OP_ADC: begin
                res        = sum[WIDTH-1:0];
                flags[F_H] = hsum[HW];
                flags[F_C] = sum[WIDTH];
            end
            OP_SUB, OP_SBC, OP_CP: begin
                res        = dif[WIDTH-1:0];
                flags[F_N] = 1'b1;
                flags[F_H] = hdif[HW];
                flags[F_C] = dif[WIDTH];
            end
            OP_AND: begin
                res        = a & b;
                flags[F_H] = 1'b1;
            end
            OP_XOR: res = a ^ b;
            default: res = a | b;
        endcase
        flags[F_Z] = (res == '0);
    end

endmodule

// File: rtl/alu_sweep_checker.sv
// Exhaustive operand sweep engine for SM83-style ALUs.
// Drives every (op,a,b), samples LAT cycles later, counts mismatches.
module alu_sweep_checker
    import alu_sweep_checker_pkg::*;
#(
    parameter int         WIDTH     = 8,
    parameter int         LAT       = 1,
    parameter logic [7:0] MODE_MASK = 8'hFF,
    parameter int         ERRW      = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 cin,
    alu_sweep_checker_if.master  bus,
    output logic                 busy,
    output logic                 done,
    output logic [ERRW-1:0]      err_count,
    output logic                 first_err_valid,
    output logic [2*WIDTH+2:0]   first_err
);
    localparam int               WW    = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [WW-1:0]    WLAST = WW'((LAT > 1) ? LAT - 2 : 0);
    localparam logic [WIDTH-1:0] VMAX  = '1;
    localparam logic [3:0]       FIRST = op_after(MODE_MASK, 4'd0);

    logic [2:0]         state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [3:0]         flg_q, flg_d;
    logic               cin_q, cin_d;
    logic [WW-1:0]      wcnt_q, wcnt_d;
    logic [ERRW-1:0]    err_q, err_d;
    logic               fev_q, fev_d;
    logic [2*WIDTH+2:0] fe_q, fe_d;
    logic [WIDTH-1:0]   g_res;
    logic [3:0]         g_flg;
    logic [3:0]         nxt_op;
    logic               mis;

    alu_golden #(.WIDTH(WIDTH)) u_gold (
        .op    (op_q),
        .a     (a_q),
        .b     (b_q),
        .cin   (cin_q),
        .res   (g_res),
        .flags (g_flg)
    );

    assign nxt_op = op_after(MODE_MASK, {1'b0, op_q} + 4'd1);
    assign mis    = (flg_q !== g_flg)
                  || ((op_q != OP_CP) && (res_q !== g_res));

    assign bus.op_a   = a_q;
    assign bus.op_b   = b_q;
    assign bus.op_sel = op_q;
    assign bus.op_cin = cin_q & ((op_q == OP_ADC) | (op_q == OP_SBC));

    assign busy = (state_q == S_APPLY) | (state_q == S_WAIT)
                | (state_q == S_CHECK);
    assign done = (state_q == S_DONE);
    assign err_count       = err_q;
    assign first_err_valid = fev_q;
    assign first_err       = fe_q;

    // Sweep FSM: sample on the edge entering CHECK, score and advance on its exit.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        flg_d   = flg_q;
        cin_d   = cin_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        fev_d   = fev_q;
        fe_d    = fe_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        err_d   = '0;
                        fev_d   = 1'b0;
                        fe_d    = '0;
                        a_d     = '0;
                        b_d     = '0;
                        op_d    = FIRST[2:0];
                        cin_d   = cin;
                        state_d = FIRST[3] ? S_APPLY : S_DONE;
                    end
                end
                S_APPLY: begin
                    res_d   = bus.dut_res;
                    flg_d   = bus.dut_flags;
                    wcnt_d  = '0;
                    state_d = (LAT == 1) ? S_CHECK : S_WAIT;
                end
                S_WAIT: begin
                    res_d  = bus.dut_res;
                    flg_d  = bus.dut_flags;
                    wcnt_d = wcnt_q + WW'(1);
                    if (wcnt_q == WLAST) begin
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (mis) begin
                        if (err_q != '1) begin
                            err_d = err_q + ERRW'(1);
                        end
                        if (!fev_q) begin
                            fev_d = 1'b1;
                            fe_d  = {op_q, a_q, b_q};
                        end
                    end
                    b_d     = b_q + WIDTH'(1);
                    cin_d   = cin;
                    state_d = S_APPLY;
                    if (b_q == VMAX) begin
                        a_d = a_q + WIDTH'(1);
                        if (a_q == VMAX) begin
                            if (nxt_op[3]) begin
                                op_d = nxt_op[2:0];
                            end else begin
                                state_d = S_DONE;
                                a_d     = a_q;
                                b_d     = b_q;
                                cin_d   = cin_q;
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            flg_q   <= '0;
            cin_q   <= 1'b0;
            wcnt_q  <= '0;
            err_q   <= '0;
            fev_q   <= 1'b0;
            fe_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            cin_q   <= cin_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fe_q    <= fe_d;
        end
    end

endmodule
